// File: rtl/eth_header_shift_register.sv
// ============================================================================
//  Module   : eth_header_shift_register
//  Purpose  : Passive AXI-Stream tap that captures the first 18 bytes of each
//             frame (MAC header + optional 802.1Q tag) for header parsers.
//  Option   : HSR_CLEAR_ON_START_EN - zero all header bytes on frame_start.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module eth_header_shift_register #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_accept,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  output logic [17:0][7:0]      header_bytes,
  output logic                  header_valid
);

  localparam int          BPB       = DATA_WIDTH / 8;
  localparam int          HDR_BYTES = 18;
  localparam logic [4:0]  OFF_FULL  = 5'd18;

  logic [17:0][7:0]    hdr_q,   hdr_d;
  logic [4:0]          off_q,   off_d;
  logic                valid_q, valid_d;
  logic                armed_q, armed_d;
  logic [4:0]          base;
  logic [BPB-1:0][7:0] beat_bytes;

  // Element BPB-1 of this view is the first byte on the wire.
  assign beat_bytes = axis_tdata;

  // Beats are only captured once a frame_start has been seen since reset,
  // so a reset mid-frame ignores the remainder of that frame.
  always_comb begin
    hdr_d   = hdr_q;
    off_d   = off_q;
    valid_d = valid_q;
    armed_d = armed_q;
    base    = off_q;

    if (frame_start) begin
      armed_d = 1'b1;
      base    = '0;
      off_d   = '0;
      valid_d = 1'b0;
`ifdef HSR_CLEAR_ON_START_EN
      hdr_d   = '0;
`endif
    end

    if (beat_accept && armed_d && (base < OFF_FULL)) begin
      for (int j = 0; j < HDR_BYTES; j++) begin
        if ((j >= int'(base)) && (j < int'(base) + BPB)) begin
          hdr_d[j] = beat_bytes[BPB - 1 - (j - int'(base))];
        end
      end
      if (int'(base) + BPB >= HDR_BYTES) begin
        off_d   = OFF_FULL;
        valid_d = 1'b1;
      end else begin
        off_d   = base + 5'(BPB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q   <= '0;
      off_q   <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hdr_q   <= hdr_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
    end
  end

  assign header_bytes = hdr_q;
  assign header_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_header_shift_register.sv
// ============================================================================
//  Module   : tb_eth_header_shift_register
//  Purpose  : Self-checking bench for eth_header_shift_register (64- and 8-bit).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eth_header_shift_register;

  logic             clk;
  logic             rst;
  logic             beat_accept;
  logic             frame_start;
  logic [63:0]      tdata64;
  logic [7:0]       tdata8;
  logic [17:0][7:0] hdr64;
  logic [17:0][7:0] hdr8;
  logic             valid64;
  logic             valid8;

  int tests_run;
  int tests_failed;

  eth_header_shift_register #(.DATA_WIDTH(64)) dut64 (
    .clk          (clk),
    .rst          (rst),
    .beat_accept  (beat_accept),
    .frame_start  (frame_start),
    .axis_tdata   (tdata64),
    .header_bytes (hdr64),
    .header_valid (valid64)
  );

  eth_header_shift_register #(.DATA_WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .beat_accept  (beat_accept),
    .frame_start  (frame_start),
    .axis_tdata   (tdata8),
    .header_bytes (hdr8),
    .header_valid (valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the header is simply "the first 18 bytes seen since frame_start".
  typedef struct packed {
    logic [17:0][7:0] hdr;
    logic [7:0]       cnt;
    logic             armed;
  } mdl_t;

  mdl_t m64;
  mdl_t m8;

  function automatic mdl_t mdl_next(mdl_t m, logic r, logic f, logic b,
                                    logic [63:0] d, int bpb);
    mdl_t nx;
    nx = m;
    if (r) begin
      nx.hdr   = '0;
      nx.cnt   = '0;
      nx.armed = 1'b0;
      return nx;
    end
    if (f) begin
      nx.armed = 1'b1;
      nx.cnt   = '0;
`ifdef HSR_CLEAR_ON_START_EN
      nx.hdr   = '0;
`endif
    end
    if (b && nx.armed) begin
      for (int k = 0; k < bpb; k++) begin
        if (nx.cnt < 8'd18) begin
          nx.hdr[nx.cnt] = d[bpb*8 - 1 - 8*k -: 8];
          nx.cnt         = nx.cnt + 8'd1;
        end
      end
    end
    return nx;
  endfunction

  // Converts a wire-order literal (first byte leftmost) into header_bytes layout.
  function automatic logic [17:0][7:0] w2p(logic [143:0] w);
    logic [17:0][7:0] r;
    for (int i = 0; i < 18; i++) r[i] = w[143 - 8*i -: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b,
                      input logic [63:0] d, input logic [7:0] d8);
    @(negedge clk);
    rst         = r;
    frame_start = f;
    beat_accept = b;
    tdata64     = d;
    tdata8      = d8;
    m64 = mdl_next(m64, r, f, b, d, 8);
    m8  = mdl_next(m8,  r, f, b, {56'd0, d8}, 1);
    @(posedge clk);
    #1;
    check("mdl64_valid", {143'd0, valid64}, {143'd0, (m64.cnt == 8'd18)});
    check("mdl64_hdr",   hdr64, m64.hdr);
    check("mdl8_valid",  {143'd0, valid8},  {143'd0, (m8.cnt == 8'd18)});
    check("mdl8_hdr",    hdr8,  m8.hdr);
  endtask

  typedef struct {
    logic             r;
    logic             f;
    logic             b;
    logic [63:0]      d;
    logic             ev;
    logic             chk;
    logic [17:0][7:0] eh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic b, input logic [63:0] d,
                     input logic ev, input logic chk, input logic [143:0] ehw);
    vec_t v;
    v.r = r; v.f = f; v.b = b; v.d = d; v.ev = ev; v.chk = chk; v.eh = w2p(ehw);
    vecs.push_back(v);
  endtask

  localparam logic [63:0]  BA = 64'h0011223344556677;
  localparam logic [63:0]  BB = 64'h8899AABB0800CCDD;
  localparam logic [63:0]  BC = 64'hEEFF112233445566;
  localparam logic [63:0]  BF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [143:0] H0 = 144'h0011223344556677_8899AABB0800CCDD_EEFF;
  localparam logic [143:0] HA = 144'h0011223344556677_0000000000000000_0000;
  localparam logic [143:0] HV = 144'h0102030405060708_1112131415161718_191A;
`ifdef HSR_CLEAR_ON_START_EN
  localparam logic [143:0] H_FS  = 144'h0;
  localparam logic [143:0] H_FSB = 144'h0102030405060708_0000000000000000_0000;
`else
  localparam logic [143:0] H_FS  = H0;
  localparam logic [143:0] H_FSB = 144'h0102030405060708_8899AABB0800CCDD_EEFF;
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; frame_start = 1'b0; beat_accept = 1'b0; tdata64 = '0; tdata8 = '0;
    m64 = '0;
    m8  = '0;

    // r f b data                 ev  chk expected header (wire order)
    add(1, 0, 0, 64'd0,                0, 1, 144'h0);
    add(0, 1, 0, 64'd0,                0, 1, 144'h0);
    add(0, 0, 1, BA,                   0, 1, HA);
    add(0, 0, 1, BB,                   0, 0, 144'h0);
    add(0, 0, 1, BC,                   1, 1, H0);
    add(0, 0, 1, BF,                   1, 1, H0);
    add(0, 0, 1, BF,                   1, 1, H0);
    add(0, 0, 0, BF,                   1, 1, H0);
    add(0, 1, 0, 64'd0,                0, 1, H_FS);
    add(0, 1, 1, 64'h0102030405060708, 0, 1, H_FSB);
    add(0, 0, 1, 64'h1112131415161718, 0, 0, 144'h0);
    add(0, 0, 1, 64'h191A1B1C1D1E1F20, 1, 1, HV);
    // idle gaps between beats
    add(0, 1, 0, 64'd0,                0, 0, 144'h0);
    add(0, 0, 1, BA,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 1, BB,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 0, BF,                   0, 0, 144'h0);
    add(0, 0, 1, BC,                   1, 1, H0);
    // reset mid-capture
    add(0, 1, 0, 64'd0,                0, 0, 144'h0);
    add(0, 0, 1, 64'h0102030405060708, 0, 0, 144'h0);
    add(1, 0, 0, 64'd0,                0, 1, 144'h0);
    add(0, 0, 1, BB,                   0, 1, 144'h0);
    add(0, 0, 1, BC,                   0, 1, 144'h0);
    add(0, 1, 1, BA,                   0, 1, HA);

    step(1, 0, 0, 64'd0, 8'd0);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].d, vecs[i].d[7:0]);
      check($sformatf("tbl%0d_valid", i), {143'd0, valid64}, {143'd0, vecs[i].ev});
      if (vecs[i].chk) check($sformatf("tbl%0d_hdr", i), hdr64, vecs[i].eh);
    end

    // 8-bit path: 18 single-byte beats, valid only after the last
    step(1, 0, 0, 64'd0, 8'd0);
    step(0, 1, 0, 64'd0, 8'd0);
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 1, 64'd0, 8'(i));
      check($sformatf("dw8_valid_beat%0d", i), {143'd0, valid8}, {143'd0, (i == 17)});
    end
    check("dw8_hdr", hdr8, w2p(144'h000102030405060708090A0B0C0D0E0F1011));
    step(0, 0, 1, 64'd0, 8'hA5);
    check("dw8_hold", hdr8, w2p(144'h000102030405060708090A0B0C0D0E0F1011));

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1) == 1, {$urandom, $urandom}, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eth_header_shift_register.md
Name: eth_header_shift_register

Overview:
- Captures the first 18 bytes of each Ethernet frame from an AXI-Stream data path: 14-byte MAC header plus an optional 4-byte 802.1Q tag.
- Presents the captured bytes as a byte array, with a valid flag, to downstream header parsers (MAC/ethertype/VLAN extraction).
- Sits beside the stream path as a passive tap; it never applies backpressure.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8, range 8..256; BPB = DATA_WIDTH/8 bytes per beat.
- Internal constant HDR_BYTES = 18; not overridable.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- beat_accept  input  1  a stream beat is transferred this cycle (tvalid & tready, computed upstream).
- frame_start  input  1  one-cycle pulse marking the start of a new frame.
- axis_tdata  input  DATA_WIDTH  beat data; byte 0 of the beat is bits [DATA_WIDTH-1 -: 8] (big-endian within the beat).
- header_bytes  output  18x8 packed ([17:0][7:0])  captured header; index 0 = first byte on the wire.
- header_valid  output  1  all 18 header bytes captured for the current frame.

Behaviour:
- Reset (rst=1 at a clock edge): header_bytes = all zero, header_valid = 0, internal byte offset = 0. Reset has priority over all other inputs. A reset mid-capture discards the partial header.
- Internal byte offset counter (width 5) tracks how many header bytes have been captured; it saturates at 18.
- frame_start=1 without beat_accept: offset <= 0 and header_valid <= 0.
  - header_bytes are retained, or cleared to zero if HSR_CLEAR_ON_START_EN is defined.
- Accepted beat (beat_accept=1), offset < 18:
  - For k in 0..BPB-1 with offset+k < 18: header_bytes[offset+k] <= axis_tdata[DATA_WIDTH-1-8k -: 8].
  - offset <= min(offset+BPB, 18).
- Accepted beat, offset already 18: no change. Payload beats never disturb the captured header.
- frame_start and beat_accept in the same cycle: the beat is the first beat of the new frame. It is written at offset 0, offset becomes min(BPB, 18), and header_valid is cleared unless BPB >= 18.
- A beat whose bytes straddle byte 17: only bytes up to index 17 are written; the rest are dropped.
- header_valid is registered. It goes 1 at the same clock edge that writes byte 17, so it is visible the cycle after that beat. It stays 1 until the next frame_start or reset.
- Latency: DATA_WIDTH=64 needs 3 beats. header_valid is high one cycle after the third accepted beat, and bytes 16/17 come from the two MSBytes of beat 2.
- Frames shorter than 18 bytes leave header_valid=0. Downstream treats such a header as invalid.
- Idle cycles (beat_accept=0) between beats hold all state.
- header_bytes drive directly from registers; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: HSR_CLEAR_ON_START_EN.
- Defined: frame_start (including frame_start coincident with a beat, before that beat's write) clears every header byte not written by that beat to 8'h00. Stale bytes from the previous frame are never visible.
- Undefined: header_bytes not yet overwritten keep their previous-frame values until rewritten. Reset still clears them to zero.

Test Plan:
- DATA_WIDTH=64, frame_start, then beats 64'h0011223344556677, 64'h8899AABB0800CCDD, 64'hEEFF112233445566 → header_valid=1 one cycle after beat 2; header_bytes[0..5]=00..55, [6..11]=66,77,88,99,AA,BB, [12..13]=08,00, [14..17]=CC,DD,EE,FF.
- After the above, two more beats 64'hFFFF_FFFF_FFFF_FFFF → header_bytes unchanged, header_valid stays 1.
- New frame_start → header_valid=0 next cycle. With HSR_CLEAR_ON_START_EN all bytes read 00; without it, bytes keep the prior values.
- frame_start coincident with beat 64'h0102030405060708 → header_bytes[0..7]=01..08, header_valid=0; two further beats complete the header and assert header_valid.
- Idle gaps (beat_accept=0 for 3 cycles) between beats → identical capture to back-to-back beats; rst=1 after beat 1 → all outputs zero, later beats ignored until the next frame_start.
- DATA_WIDTH=8, 18 single-byte beats 0x00..0x11 → header_bytes[i]=i, header_valid high only after the 18th beat.
